tt_sweep_checker: RTL and testbench

//  Self-running exhaustive truth-table checker for an N-input, 1-output combinational DUT.

---
 rtl/tt_sweep_checker.sv | 117 +++++++++++
 tb/tb_tt_sweep_checker.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_sweep_checker.sv
// tt_sweep_checker: self-running exhaustive truth-table checker.
// Steps an N_IN-input combinational DUT through every input vector in
// ascending order. Each vector is held for HOLD cycles. The DUT output is
// sampled at the end of each hold window and compared to EXP_TT. The block
// reports a mismatch count, the first failing vector and the observed table.
module tt_sweep_checker #(
  parameter int N_IN = 4,
  parameter int HOLD = 20,
  parameter logic [(1<<N_IN)-1:0] EXP_TT = '0,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [N_IN-1:0]      vec_out,
  input  logic                 dut_f,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N_IN:0]        err_count,
  output logic                 fail_valid,
  output logic [N_IN-1:0]      first_fail_vec,
  output logic [(1<<N_IN)-1:0] obs_tt
);

  localparam int NV = 1 << N_IN;
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [N_IN-1:0] VEC_LAST = N_IN'(NV - 1);
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD - 1);

  typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [HW-1:0]   hold_cnt;
  logic            start_ok;
  logic            sample;
  logic            mismatch;
  logic            last_vec;
  logic            finish;

  // Start is only honoured while no sweep is running.
  assign start_ok = start && (state != APPLY);
  assign sample   = (state == APPLY) && (hold_cnt == HOLD_LAST);
  assign mismatch = sample && (dut_f != EXP_TT[vec_out]);
  assign last_vec = (vec_out == VEC_LAST);
  // The sweep ends on the last sample, or on the first mismatch when stopping early.
  assign finish   = sample && (last_vec || (STOP_ON_FAIL && mismatch));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and status outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = APPLY;
      end
      APPLY: begin
        busy = 1'b1;
        if (finish) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = APPLY;
      end
      default: state_nxt = IDLE;
    endcase
    pass = done && (err_count == '0);
  end

  // Vector stepping, hold timing and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_out        <= '0;
      hold_cnt       <= '0;
      err_count      <= '0;
      fail_valid     <= 1'b0;
      first_fail_vec <= '0;
      obs_tt         <= '0;
    end else if (start_ok) begin
      vec_out        <= '0;
      hold_cnt       <= '0;
      err_count      <= '0;
      fail_valid     <= 1'b0;
      first_fail_vec <= '0;
      obs_tt         <= '0;
    end else if (state == APPLY) begin
      if (sample) begin
        obs_tt[vec_out] <= dut_f;
        if (mismatch) begin
          err_count <= err_count + 1'b1;
          if (!fail_valid) begin
            fail_valid     <= 1'b1;
            first_fail_vec <= vec_out;
          end
        end
        if (!finish) begin
          vec_out  <= vec_out + 1'b1;
          hold_cnt <= '0;
        end
      end else begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Bench for tt_sweep_checker: three checker instances (full sweep,
// stop-on-fail, HOLD=1 with two inputs) each driving a small reference DUT.
module tb_tt_sweep_checker;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic fsel_a = 1'b0;

  always #5 clk = ~clk;

  // Instance A: N_IN=4, HOLD=20, run-to-end
  logic [3:0]  vec_a, ffv_a;
  logic        f_a, busy_a, done_a, pass_a, fv_a;
  logic [4:0]  err_a;
  logic [15:0] obs_a;
  assign f_a = fsel_a ? (vec_a[3] & vec_a[2]) : (^vec_a);

  tt_sweep_checker #(.N_IN(4), .HOLD(20), .EXP_TT(16'h6996), .STOP_ON_FAIL(1'b0)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .vec_out(vec_a), .dut_f(f_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .fail_valid(fv_a), .first_fail_vec(ffv_a), .obs_tt(obs_a));

  // Instance B: N_IN=4, HOLD=20, stop at first mismatch, f=a&b
  logic [3:0]  vec_b, ffv_b;
  logic        f_b, busy_b, done_b, pass_b, fv_b;
  logic [4:0]  err_b;
  logic [15:0] obs_b;
  assign f_b = vec_b[3] & vec_b[2];

  tt_sweep_checker #(.N_IN(4), .HOLD(20), .EXP_TT(16'h6996), .STOP_ON_FAIL(1'b1)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .vec_out(vec_b), .dut_f(f_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .fail_valid(fv_b), .first_fail_vec(ffv_b), .obs_tt(obs_b));

  // Instance C: N_IN=2, HOLD=1, f=a|b
  logic [1:0]  vec_c, ffv_c;
  logic        f_c, busy_c, done_c, pass_c, fv_c;
  logic [2:0]  err_c;
  logic [3:0]  obs_c;
  assign f_c = vec_c[1] | vec_c[0];

  tt_sweep_checker #(.N_IN(2), .HOLD(1), .EXP_TT(4'hE), .STOP_ON_FAIL(1'b0)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .vec_out(vec_c), .dut_f(f_c),
    .busy(busy_c), .done(done_c), .pass(pass_c), .err_count(err_c),
    .fail_valid(fv_c), .first_fail_vec(ffv_c), .obs_tt(obs_c));

  typedef struct {
    logic        busy, done, pass, fv;
    logic [4:0]  err;
    logic [3:0]  ffv, vec;
    logic [15:0] obs;
  } outs_t;

  typedef struct {
    logic [4:0]  err;
    logic [3:0]  ffv, vec;
    logic        fv, pass;
    logic [15:0] obs;
    int          cycles;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic outs_t get(input int inst);
    outs_t o;
    case (inst)
      0: o = '{busy_a, done_a, pass_a, fv_a, err_a, ffv_a, vec_a, obs_a};
      1: o = '{busy_b, done_b, pass_b, fv_b, err_b, ffv_b, vec_b, obs_b};
      default: o = '{busy_c, done_c, pass_c, fv_c, {2'b0, err_c}, {2'b0, ffv_c},
                     {2'b0, vec_c}, {12'b0, obs_c}};
    endcase
    return o;
  endfunction

  task automatic set_start(input int inst, input logic v);
    case (inst)
      0: start_a = v;
      1: start_b = v;
      default: start_c = v;
    endcase
  endtask

  // Reference behaviour: walk every vector, evaluate the reference function,
  // accumulate mismatches against the expected table.
  function automatic exp_t model(input int n, input int hold, input logic [15:0] tt,
                                 input bit sof, input int fsel);
    exp_t e;
    bit   stop;
    e.err = '0; e.ffv = '0; e.vec = '0; e.fv = 1'b0; e.obs = '0; e.cycles = 0;
    stop = 1'b0;
    for (int i = 0; i < (1 << n); i++) begin
      logic [7:0] v;
      logic f;
      if (!stop) begin
        v = 8'(i);
        case (fsel)
          0:       f = ^v[3:0];
          1:       f = v[n-1] & v[n-2];
          default: f = v[n-1] | v[n-2];
        endcase
        e.obs[i] = f;
        e.vec    = 4'(i);
        e.cycles = (i + 1) * hold;
        if (f !== tt[i]) begin
          e.err = e.err + 1'b1;
          if (!e.fv) begin
            e.fv  = 1'b1;
            e.ffv = 4'(i);
          end
          if (sof) stop = 1'b1;
        end
      end
    end
    e.pass = (e.err == 0);
    return e;
  endfunction

  // Start a sweep, optionally pulse start again at cycle 'poke', wait for done
  // within 'limit' cycles and compare against the front of the scoreboard.
  task automatic run(input int inst, input int limit, input int poke, input string nm);
    exp_t  e;
    outs_t o;
    int    cnt;
    @(negedge clk);
    set_start(inst, 1'b1);
    @(posedge clk);
    #1 set_start(inst, 1'b0);
    cnt = 0;
    @(negedge clk);
    o = get(inst);
    chk({nm, "_busy_at_start"}, 32'(o.busy), 32'd1);
    chk({nm, "_done_at_start"}, 32'(o.done), 32'd0);
    chk({nm, "_err_cleared"},   32'(o.err),  32'd0);
    chk({nm, "_obs_cleared"},   32'(o.obs),  32'd0);
    chk({nm, "_fv_cleared"},    32'(o.fv),   32'd0);
    while (!o.done && cnt < limit) begin
      if (inst == 2) chk({nm, "_vec_step"}, 32'(o.vec), 32'(cnt));
      set_start(inst, (cnt == poke) ? 1'b1 : 1'b0);
      @(posedge clk);
      cnt++;
      @(negedge clk);
      o = get(inst);
    end
    set_start(inst, 1'b0);
    if (sb.size() == 0) begin
      chk({nm, "_scoreboard_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({nm, "_cycles"}, 32'(cnt),    32'(e.cycles));
      chk({nm, "_done"},   32'(o.done), 32'd1);
      chk({nm, "_busy"},   32'(o.busy), 32'd0);
      chk({nm, "_pass"},   32'(o.pass), 32'(e.pass));
      chk({nm, "_err"},    32'(o.err),  32'(e.err));
      chk({nm, "_fv"},     32'(o.fv),   32'(e.fv));
      chk({nm, "_ffv"},    32'(o.ffv),  32'(e.ffv));
      chk({nm, "_obs"},    32'(o.obs),  32'(e.obs));
      chk({nm, "_vec"},    32'(o.vec),  32'(e.vec));
    end
  endtask

  task automatic chk_zero(input int inst, input string nm);
    outs_t o;
    o = get(inst);
    chk({nm, "_vec"},  32'(o.vec),  32'd0);
    chk({nm, "_busy"}, 32'(o.busy), 32'd0);
    chk({nm, "_done"}, 32'(o.done), 32'd0);
    chk({nm, "_pass"}, 32'(o.pass), 32'd0);
    chk({nm, "_err"},  32'(o.err),  32'd0);
    chk({nm, "_fv"},   32'(o.fv),   32'd0);
    chk({nm, "_ffv"},  32'(o.ffv),  32'd0);
    chk({nm, "_obs"},  32'(o.obs),  32'd0);
  endtask

  initial begin
    outs_t o;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero(0, "rst_a");
    chk_zero(1, "rst_b");
    chk_zero(2, "rst_c");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // XOR DUT, correct table; start pulsed mid-sweep must be ignored
    sb.push_back(model(4, 20, 16'h6996, 1'b0, 0));
    run(0, 2000, 50, "xor");

    // a&b DUT against the parity table, full sweep (start from DONE)
    fsel_a = 1'b1;
    sb.push_back(model(4, 20, 16'h6996, 1'b0, 1));
    run(0, 2000, -1, "and_full");

    // Restart from DONE after a failing sweep: statistics must clear
    fsel_a = 1'b0;
    sb.push_back(model(4, 20, 16'h6996, 1'b0, 0));
    run(0, 2000, -1, "restart");

    // Stop-on-fail instance
    sb.push_back(model(4, 20, 16'h6996, 1'b1, 1));
    run(1, 2000, -1, "stop");

    // HOLD=1, two inputs, f=a|b
    sb.push_back(model(2, 1, 16'h000E, 1'b0, 2));
    run(2, 100, -1, "hold1");

    // Reset in the middle of a sweep aborts immediately
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    repeat (100) @(posedge clk);
    #3;
    o = get(0);
    chk("pre_abort_busy", 32'(o.busy), 32'd1);
    chk("pre_abort_vec_nonzero", 32'(o.vec != 0), 32'd1);
    rst = 1'b1;
    #1 chk_zero(0, "abort");
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    o = get(0);
    chk("no_self_start_busy", 32'(o.busy), 32'd0);
    chk("no_self_start_done", 32'(o.done), 32'd0);
    sb.push_back(model(4, 20, 16'h6996, 1'b0, 0));
    run(0, 2000, -1, "after_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
